// File: rtl/mat_trans_arb.sv
// mat_trans_arb: round-robin job scheduler sharing one mat_trans engine
// (8x8 transpose) between NUM_REQ requesters, one whole matrix per job.
// Optional macro MAT_TRANS_ARB_STATS_EN adds job_cnt / last_id outputs.
module mat_trans_arb #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAT_WORDS = 64,
  parameter int unsigned IDW       = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_REQ-1:0]    s_req,
  output logic [NUM_REQ-1:0]    s_ack,
  input  logic [NUM_REQ-1:0]    s_vld,
  input  logic [NUM_REQ*DW-1:0] s_data,
  output logic                  eng_in_req,
  input  logic                  eng_in_ack,
  output logic                  eng_in_vld,
  output logic [DW-1:0]         eng_in_data,
  input  logic                  eng_out_req,
  output logic                  eng_out_ack,
  input  logic                  eng_out_vld,
  input  logic [DW-1:0]         eng_out_data,
  output logic                  out_req,
  input  logic                  out_ack,
  output logic                  out_vld,
  output logic [DW-1:0]         out_data,
  output logic [IDW-1:0]        out_id,
  output logic                  busy
`ifdef MAT_TRANS_ARB_STATS_EN
  ,
  output logic [15:0]           job_cnt,
  output logic [IDW-1:0]        last_id
`endif
);

  localparam int unsigned CW = $clog2(MAT_WORDS) + 1;

  typedef enum logic [2:0] {IDLE, GRANT, LOAD, WAIT_OUT, DRAIN} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] rr_ptr;
  logic           pick_vld;
  logic [IDW-1:0] pick_id;
  logic [IDW-1:0] idx;
  logic [DW-1:0]  s_word [NUM_REQ];
  logic           job_done_c;

  // Unpack the requester data bus into one word per requester
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) s_word[i] = s_data[i*DW +: DW];
  end

  // Round-robin pick: first requesting index after rr_ptr, with wrap
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((32'(rr_ptr) + k) % NUM_REQ);
      if (!pick_vld && s_req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

  assign job_done_c = (state == DRAIN) && eng_out_vld && (cnt == CW'(MAT_WORDS - 1));

  // Job sequencer: grant, load 64 words, hand-off, drain 64 words
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt_id     <= '0;
      rr_ptr     <= IDW'(NUM_REQ - 1);
      s_ack      <= '0;
      eng_in_req <= 1'b0;
      busy       <= 1'b0;
    end else begin
      s_ack <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt_id     <= pick_id;
            eng_in_req <= 1'b1;
            busy       <= 1'b1;
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (eng_in_ack) begin
            s_ack <= NUM_REQ'(1) << gnt_id;
            cnt   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (s_vld[gnt_id]) begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(MAT_WORDS - 1)) begin
              eng_in_req <= 1'b0;
              state      <= WAIT_OUT;
            end
          end
        end
        WAIT_OUT: begin
          if (eng_out_req && out_ack) begin
            cnt   <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (eng_out_vld) begin
            cnt <= cnt + CW'(1);
            if (job_done_c) begin
              rr_ptr <= gnt_id;
              busy   <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-latency data paths, only open in their owning states
  assign eng_in_vld  = (state == LOAD) && s_vld[gnt_id];
  assign eng_in_data = (state == LOAD) ? s_word[gnt_id] : '0;
  assign out_req     = (state == WAIT_OUT) && eng_out_req;
  assign eng_out_ack = (state == WAIT_OUT) && out_ack;
  assign out_vld     = (state == DRAIN) && eng_out_vld;
  assign out_data    = (state == DRAIN) ? eng_out_data : '0;
  assign out_id      = ((state == WAIT_OUT) || (state == DRAIN)) ? gnt_id : '0;

`ifdef MAT_TRANS_ARB_STATS_EN
  // Completed-job counter (saturating) and owner of the last finished job
  always_ff @(posedge clk) begin
    if (!rstn) begin
      job_cnt <= '0;
      last_id <= '0;
    end else if (job_done_c) begin
      job_cnt <= (job_cnt == 16'hFFFF) ? job_cnt : job_cnt + 16'd1;
      last_id <= gnt_id;
    end
  end
`endif

endmodule

// File: tb/tb_mat_trans_arb.sv
// Testbench for mat_trans_arb: random requesters, a behavioural transpose
// engine and consumer, checked against a round-robin/transpose reference.
module tb_mat_trans_arb;
  localparam int unsigned NUM_REQ = 4, DW = 32, MAT_WORDS = 64, IDW = 2;
  localparam int E_IDLE = 0, E_COLLECT = 1, E_COMP = 2, E_OFFER = 3, E_STREAM = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [NUM_REQ-1:0] s_req, s_ack, s_vld;
  logic [NUM_REQ*DW-1:0] s_data;
  logic eng_in_req, eng_in_ack, eng_in_vld;
  logic [DW-1:0] eng_in_data;
  logic eng_out_req, eng_out_ack, eng_out_vld;
  logic [DW-1:0] eng_out_data;
  logic out_req, out_ack, out_vld;
  logic [DW-1:0] out_data;
  logic [IDW-1:0] out_id;
  logic busy;
`ifdef MAT_TRANS_ARB_STATS_EN
  logic [15:0] job_cnt;
  logic [IDW-1:0] last_id;
`endif

  always #5 clk = ~clk;

  mat_trans_arb #(.NUM_REQ(NUM_REQ), .DW(DW), .MAT_WORDS(MAT_WORDS), .IDW(IDW)) dut (
    .clk(clk), .rstn(rstn), .s_req(s_req), .s_ack(s_ack), .s_vld(s_vld), .s_data(s_data),
    .eng_in_req(eng_in_req), .eng_in_ack(eng_in_ack), .eng_in_vld(eng_in_vld),
    .eng_in_data(eng_in_data), .eng_out_req(eng_out_req), .eng_out_ack(eng_out_ack),
    .eng_out_vld(eng_out_vld), .eng_out_data(eng_out_data), .out_req(out_req),
    .out_ack(out_ack), .out_vld(out_vld), .out_data(out_data), .out_id(out_id), .busy(busy)
`ifdef MAT_TRANS_ARB_STATS_EN
    , .job_cnt(job_cnt), .last_id(last_id)
`endif
  );

  int unsigned n_chk = 0, n_bad = 0;
  int req_st [NUM_REQ];   // 0 idle, 1 requesting, 2 sending
  int sent [NUM_REQ];
  int tot [NUM_REQ];
  logic tog [NUM_REQ];
  logic [DW-1:0] in_words [MAT_WORDS];
  logic [DW-1:0] e_buf [MAT_WORDS];
  int gen_pct = 0, vld_mode = 0, extra_fix = 0, reset_at = 0, rereq = 0;
  logic stall_next = 1'b0;
  int e_ph = E_IDLE, e_cnt = 0, e_dly = 0, o_idx = 0, stall_cnt = 0;
  logic [NUM_REQ-1:0] snap = '0;
  int rr_last = NUM_REQ - 1, exp_gnt = 0;
  logic ack_due = 1'b0, idle_due = 1'b0, rst_req = 1'b0;
  int jobs_done = 0, jobs_rst = 0, last_done = 0;
  int glog [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next requester after 'last' in circular order that is requesting
  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
    for (int k = 1; k <= NUM_REQ; k++)
      if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  // Output word k of the transpose comes from input word (k/8) + (k%8)*8
  function automatic int tidx(input int k);
    return (k / 8) + (k % 8) * 8;
  endfunction

  task automatic reset_seq();
    @(negedge clk);
    rstn = 1'b0;
    s_req = '0; s_vld = '0; s_data = '0; eng_in_ack = 0; eng_out_req = 0;
    eng_out_vld = 0; eng_out_data = '0; out_ack = 0;
    for (int i = 0; i < NUM_REQ; i++) begin req_st[i] = 0; sent[i] = 0; end
    e_ph = E_IDLE; stall_cnt = 0; ack_due = 0; idle_due = 0; rst_req = 0;
    snap = '0; rr_last = NUM_REQ - 1; jobs_rst = 0; last_done = 0;
    @(negedge clk);
    check("rst_s_ack", 32'(s_ack), 0);
    check("rst_in_req", 32'(eng_in_req), 0);
    check("rst_in_vld", 32'(eng_in_vld), 0);
    check("rst_in_data", eng_in_data, 0);
    check("rst_out_ack", 32'(eng_out_ack), 0);
    check("rst_out_req", 32'(out_req), 0);
    check("rst_out_vld", 32'(out_vld), 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", 32'(out_id), 0);
    check("rst_busy", 32'(busy), 0);
`ifdef MAT_TRANS_ARB_STATS_EN
    check("rst_job_cnt", 32'(job_cnt), 0);
    check("rst_last_id", 32'(last_id), 0);
`endif
    rstn = 1'b1;
  endtask

  // One clock: drive at negedge, check just after, transfers land at posedge
  task automatic cycle();
    logic [NUM_REQ-1:0] rq, vl;
    logic [NUM_REQ*DW-1:0] dt;
    logic x_vld, i_ack, o_req, o_ack, o_vld;
    logic [DW-1:0] x_dat, o_dat;
    int ph;
    @(negedge clk);
    check("s_ack", 32'(s_ack), ack_due ? (32'(1) << exp_gnt) : 32'd0);
    for (int i = 0; i < NUM_REQ; i++) if (s_ack[i]) glog.push_back(i);
    if (ack_due) begin
      req_st[exp_gnt] = 2; sent[exp_gnt] = 0; tog[exp_gnt] = 1'b1;
      tot[exp_gnt] = MAT_WORDS + ((extra_fix >= 0) ? extra_fix : int'($urandom_range(0, 2)));
      ack_due = 0;
    end
    if (idle_due) begin
      check("busy_end", 32'(busy), 0);
`ifdef MAT_TRANS_ARB_STATS_EN
      check("job_cnt", 32'(job_cnt), 32'(jobs_rst));
      check("last_id", 32'(last_id), 32'(last_done));
`endif
      idle_due = 0;
    end
    if (e_ph == E_IDLE) check("in_req_idle", 32'(eng_in_req), 32'(busy));
    else if (e_ph == E_COLLECT) check("in_req_load", 32'(eng_in_req), 1);
    else check("in_req_off", 32'(eng_in_req), 0);

    x_vld = 0; x_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      logic v;
      logic [DW-1:0] d;
      d = $urandom;
      v = ($urandom_range(0, 1) == 1);
      if (req_st[i] == 0 && gen_pct > 0 && int'($urandom_range(0, 99)) < gen_pct) req_st[i] = 1;
      if (req_st[i] == 2) begin
        case (vld_mode)
          1: v = tog[i];
          2: v = 1'b1;
          default: v = ($urandom_range(0, 9) < 7);
        endcase
        tog[i] = ~tog[i];
        if (v) begin
          if (sent[i] < MAT_WORDS) begin in_words[sent[i]] = d; x_vld = 1; x_dat = d; end
          sent[i]++;
          if (reset_at > 0 && sent[i] == reset_at) begin rst_req = 1; reset_at = 0; end
          if (sent[i] == tot[i]) req_st[i] = rereq ? 1 : 0;
        end
      end
      rq[i] = (req_st[i] == 1);
      vl[i] = v;
      dt[i*DW +: DW] = d;
    end

    i_ack = 0; o_req = 0; o_vld = 0; o_dat = '0;
    if (e_ph == E_IDLE && eng_in_req && $urandom_range(0, 3) == 0) i_ack = 1;
    if (e_ph == E_COMP) begin
      if (e_dly == 0) begin
        e_ph = E_OFFER;
        if (stall_next) begin stall_cnt = 100; stall_next = 0; end
      end else e_dly--;
    end
    if (e_ph == E_OFFER) o_req = 1;
    if (e_ph == E_STREAM) begin
      o_vld = ($urandom_range(0, 2) != 0);
      o_dat = o_vld ? e_buf[tidx(o_idx)] : DW'($urandom);
    end
    o_ack = (stall_cnt > 0) ? 1'b0 : 1'($urandom_range(0, 1));
    if (stall_cnt > 0 && e_ph == E_OFFER) stall_cnt--;
    ph = e_ph;

    s_req = rq; s_vld = vl; s_data = dt; eng_in_ack = i_ack; eng_out_req = o_req;
    eng_out_vld = o_vld; eng_out_data = o_dat; out_ack = o_ack;
    #1;

    check("in_vld", 32'(eng_in_vld), 32'(x_vld));
    if (x_vld) check("in_data", eng_in_data, x_dat);
    if (i_ack) begin
      exp_gnt = rr_pick(snap, rr_last);
      check("arb_any", 32'(exp_gnt >= 0), 1);
      if (exp_gnt < 0) exp_gnt = 0;
      rr_last = exp_gnt; ack_due = 1; e_ph = E_COLLECT; e_cnt = 0;
    end else if (ph == E_COLLECT && eng_in_vld) begin
      e_buf[e_cnt] = eng_in_data;
      e_cnt++;
      if (e_cnt == MAT_WORDS) begin e_ph = E_COMP; e_dly = $urandom_range(0, 4); end
    end
    if (ph == E_COMP || ph == E_OFFER) begin
      check("out_req", 32'(out_req), 32'(o_req));
      check("eng_out_ack", 32'(eng_out_ack), 32'(o_ack));
      check("out_id_wait", 32'(out_id), 32'(exp_gnt));
      if (ph == E_OFFER && o_ack) begin e_ph = E_STREAM; o_idx = 0; end
    end else begin
      check("out_req_off", 32'(out_req), 0);
      check("eng_out_ack_off", 32'(eng_out_ack), 0);
    end
    if (ph == E_STREAM) begin
      check("out_vld", 32'(out_vld), 32'(o_vld));
      check("out_id_drain", 32'(out_id), 32'(exp_gnt));
      if (o_vld) begin
        check("out_data", out_data, in_words[tidx(o_idx)]);
        o_idx++;
        if (o_idx == MAT_WORDS) begin
          e_ph = E_IDLE; idle_due = 1; jobs_done++; jobs_rst++; last_done = exp_gnt;
        end
      end
    end else check("out_vld_off", 32'(out_vld), 0);
    if (!busy) snap = rq;
  endtask

  task automatic run_jobs(input int n, input int budget);
    int tgt, cyc;
    tgt = jobs_done + n;
    cyc = 0;
    while (jobs_done < tgt && cyc < budget) begin
      if (rst_req) reset_seq(); else cycle();
      cyc++;
    end
    check("timeout", 32'(jobs_done >= tgt), 1);
  endtask

  initial begin
    int seq [5];
    int c;
    seq = '{0, 1, 2, 3, 0};
    s_req = '0; s_vld = '0; s_data = '0; eng_in_ack = 0; eng_out_req = 0;
    eng_out_vld = 0; eng_out_data = '0; out_ack = 0;
    reset_seq();

    // Single job from requester 2
    glog.delete(); extra_fix = 0; req_st[2] = 1;
    run_jobs(1, 2000);
    check("single_n", 32'(glog.size()), 1);
    if (glog.size() > 0) check("single_id", 32'(glog[0]), 2);

    // All four requesting: strict rotation 0,1,2,3,0
    reset_seq(); glog.delete(); rereq = 1; vld_mode = 2;
    for (int i = 0; i < NUM_REQ; i++) req_st[i] = 1;
    run_jobs(5, 4000);
    rereq = 0;
    for (int k = 0; k < 5; k++)
      check($sformatf("rot%0d", k), (k < glog.size()) ? 32'(glog[k]) : 32'hFFFF_FFFF, 32'(seq[k]));

    // Gapped input with one surplus word
    reset_seq(); vld_mode = 1; extra_fix = 1; req_st[1] = 1;
    run_jobs(1, 2000);

    // Consumer stall of 100 cycles
    reset_seq(); vld_mode = 0; extra_fix = 0; stall_next = 1; req_st[3] = 1;
    run_jobs(1, 2000);

    // Reset at word 30 of LOAD, then a fresh job goes to requester 0
    reset_seq(); req_st[2] = 1; reset_at = 30;
    c = 0;
    while (!rst_req && c < 1000) begin cycle(); c++; end
    check("rst_hit", 32'(rst_req), 1);
    reset_seq(); glog.delete();
    for (int i = 0; i < NUM_REQ; i++) req_st[i] = 1;
    run_jobs(1, 2000);
    if (glog.size() > 0) check("post_rst_id", 32'(glog[0]), 0);

    // Random traffic
    reset_seq(); gen_pct = 8; extra_fix = -1;
    for (int r = 0; r < 6; r++) begin
      vld_mode = $urandom_range(0, 2);
      run_jobs(4, 4000);
    end
    gen_pct = 0;

`ifdef MAT_TRANS_ARB_STATS_EN
    // Three jobs from requesters 1, 3, 1
    reset_seq(); extra_fix = 0; vld_mode = 0;
    req_st[1] = 1; run_jobs(1, 2000);
    req_st[3] = 1; run_jobs(1, 2000);
    req_st[1] = 1; run_jobs(1, 2000);
    cycle();
    check("stats_cnt", 32'(job_cnt), 3);
    check("stats_id", 32'(last_id), 1);
`endif

    for (int k = 0; k < 4; k++) cycle();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
